// File: rtl/xclock_setter_pkg.sv
// xclock_setter_pkg: shared state encoding, nibble addresses and digit limits
// for the pushbutton time-setting controller.
package xclock_setter_pkg;

   typedef enum logic [2:0] {
      S_RUN,
      S_EDIT,
      S_WR,
      S_WR_FIX,
      S_CLR0,
      S_CLR1
   } state_t;

   localparam logic [3:0] ADDR_MS0  = 4'd0;
   localparam logic [3:0] ADDR_MS1  = 4'd1;
   localparam logic [3:0] ADDR_SEC0 = 4'd2;
   localparam logic [3:0] ADDR_SEC1 = 4'd3;
   localparam logic [3:0] ADDR_MIN0 = 4'd4;
   localparam logic [3:0] ADDR_MIN1 = 4'd5;
   localparam logic [3:0] ADDR_HR0  = 4'd6;
   localparam logic [3:0] ADDR_HR1  = 4'd7;

   localparam logic [3:0] MAX_UNITS  = 4'd9;
   localparam logic [3:0] MAX_TENS   = 4'd5;
   localparam logic [3:0] MAX_HR1    = 4'd2;
   localparam logic [3:0] MAX_HR0_LO = 4'd9;
   localparam logic [3:0] MAX_HR0_HI = 4'd3;

   // Hour units are limited by the hour tens digit so 20..23 stays legal.
   function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] hr1);
      return (idx == 3'd7) ? MAX_HR1 :
             (idx == 3'd6) ? ((hr1 < 4'd2) ? MAX_HR0_LO : MAX_HR0_HI) :
             (idx == 3'd3 || idx == 3'd5) ? MAX_TENS : MAX_UNITS;
   endfunction

endpackage

// File: rtl/xclock_setter_key_debounce.sv
// key_debounce: synchronises a raw key and emits a one-cycle pulse once the
// key has been stably pressed for DB_CYCLES cycles; releases give no pulse.
module key_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         pulse <= 1'b0;
         if (sync[1] == level)
            cnt <= '0;
         else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            pulse <= sync[1];
         end else
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/xclock_setter.sv
// xclock_setter: debounced three-key edit controller that freezes the BCD clock,
// writes legal digits through its nibble load port and clears hundredths on exit.
module xclock_setter
   import xclock_setter_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_mode,
   input  logic        btn_sel,
   input  logic        btn_inc,
   input  logic [31:0] q_in,
   output logic [3:0]  d,
   output logic [3:0]  addr,
   output logic        load,
   output logic        en,
   output logic        editing,
   output logic [2:0]  cursor
);

   logic mode_p, sel_p, inc_p;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (.clk(clk), .reset(reset), .key(btn_mode), .pulse(mode_p));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_sel  (.clk(clk), .reset(reset), .key(btn_sel),  .pulse(sel_p));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc  (.clk(clk), .reset(reset), .key(btn_inc),  .pulse(inc_p));

   state_t     state, state_n;
   logic [2:0] cursor_n;
   logic [3:0] d_n, addr_n, cur_val, cur_max, inc_val;
   logic       load_n, en_n, editing_n, fix;

   assign cur_val = q_in[{cursor, 2'b00} +: 4];
   assign cur_max = digit_max(cursor, q_in[31:28]);
   assign inc_val = (cur_val >= cur_max) ? 4'd0 : cur_val + 4'd1;
   // d still holds the value just written when the WR state is evaluated.
   assign fix     = (cursor == 3'd7) && (d == MAX_HR1) && (q_in[27:24] > MAX_HR0_HI);

   always_comb begin
      state_n  = state;
      cursor_n = cursor;
      load_n   = 1'b0;
      addr_n   = addr;
      d_n      = d;
      case (state)
         S_RUN: begin
            if (mode_p) begin
               state_n  = S_EDIT;
               cursor_n = 3'd7;
            end
         end
         S_EDIT: begin
            if (mode_p) begin
               state_n = S_CLR0;
               load_n  = 1'b1;
               addr_n  = ADDR_MS0;
               d_n     = 4'd0;
            end else if (sel_p)
               cursor_n = (cursor == 3'd2) ? 3'd7 : cursor - 3'd1;
            else if (inc_p) begin
               state_n = S_WR;
               load_n  = 1'b1;
               addr_n  = {1'b0, cursor};
               d_n     = inc_val;
            end
         end
         S_WR: begin
            state_n = fix ? S_WR_FIX : S_EDIT;
            load_n  = fix;
            addr_n  = fix ? ADDR_HR0 : addr;
            d_n     = fix ? MAX_HR0_HI : d;
         end
         S_WR_FIX: state_n = S_EDIT;
         S_CLR0: begin
            state_n = S_CLR1;
            load_n  = 1'b1;
            addr_n  = ADDR_MS1;
            d_n     = 4'd0;
         end
         S_CLR1:  state_n = S_RUN;
         default: state_n = S_RUN;
      endcase
      en_n      = (state_n == S_RUN);
      editing_n = (state_n == S_EDIT) || (state_n == S_WR) || (state_n == S_WR_FIX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_RUN;
         cursor  <= 3'd7;
         d       <= 4'd0;
         addr    <= 4'd0;
         load    <= 1'b0;
         en      <= 1'b1;
         editing <= 1'b0;
      end else begin
         state   <= state_n;
         cursor  <= cursor_n;
         d       <= d_n;
         addr    <= addr_n;
         load    <= load_n;
         en      <= en_n;
         editing <= editing_n;
      end
   end

endmodule
